serial_deserializer: RTL

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer_pkg.sv | 24 ++
 rtl/serial_deserializer_if.sv | 36 +++
 rtl/serial_deserializer_out_buf.sv | 98 +++++++++
 rtl/serial_deserializer.sv | 89 ++++++++
 4 files changed

// File: rtl/serial_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the serial deserializer slice:
//   DEFAULT_N   - default assembled word width in bits
//   CNT_W       - bit-counter width for the default word width
//   cnt_width() - bit-counter width for any legal word width (2..32)
//   buf_state_e - output holding register state encoding (EMPTY/FULL)
// -----------------------------------------------------------------------------
package serdes_pkg;

   localparam int DEFAULT_N = 6;
   localparam int CNT_W     = $clog2(DEFAULT_N);

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   // Counter width able to hold 0..n-1; n is at least 2, so this is at least 1.
   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// -----------------------------------------------------------------------------
// serial_deserializer_if
// Groups the serial input strobe, the word output handshake and the error
// flag of the deserializer.
//   I, in_valid, sync    - serial bit, bit strobe, frame marker (to design)
//   out_data, out_valid  - assembled word and its valid flag (from design)
//   out_ready            - consumer accepts the presented word (to design)
//   overrun, clr_err     - sticky dropped-word flag and its clear
// Modports: master = stimulus/consumer side, slave = deserializer side.
// -----------------------------------------------------------------------------
interface serial_deserializer_if
   import serdes_pkg::*;
#(
   parameter int N = DEFAULT_N
) ();

   logic         I;
   logic         in_valid;
   logic         sync;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         overrun;
   logic         clr_err;

   modport master (
      output I, in_valid, sync, out_ready, clr_err,
      input  out_data, out_valid, overrun
   );

   modport slave (
      input  I, in_valid, sync, out_ready, clr_err,
      output out_data, out_valid, overrun
   );

endinterface

// File: rtl/serial_deserializer_out_buf.sv
// -----------------------------------------------------------------------------
// deser_out_buf
// Single-entry valid/ready holding register for completed words, with sticky
// overrun detection when a word completes while the entry is still held.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   word_i        - completed word from the assembler
//   complete_i    - word_i is a finished word this cycle
//   out_ready_i   - consumer accepts the held word
//   clr_err_i     - synchronous clear of the overrun flag
//   out_data_o    - held word (registered)
//   out_valid_o   - held word not yet consumed (registered state)
//   overrun_o     - sticky: a completed word was dropped (registered)
// -----------------------------------------------------------------------------
module deser_out_buf
   import serdes_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] word_i,
   input  logic         complete_i,
   input  logic         out_ready_i,
   input  logic         clr_err_i,
   output logic [N-1:0] out_data_o,
   output logic         out_valid_o,
   output logic         overrun_o
);

   buf_state_e   state_q, state_d;
   logic [N-1:0] data_q, data_d;
   logic         overrun_q, overrun_d;
   logic         drop_s;

   // Next-state, data capture and overrun logic for the holding register.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      drop_s    = 1'b0;
      case (state_q)
         BUF_EMPTY: begin
            // out_ready while empty is deliberately ignored.
            if (complete_i) begin
               state_d = BUF_FULL;
               data_d  = word_i;
            end else begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (complete_i && out_ready_i) begin
               // Held word leaves and the new one takes its place: no bubble.
               state_d = BUF_FULL;
               data_d  = word_i;
            end else if (complete_i) begin
               // Consumer stalled: keep the held word, lose the new one.
               state_d = BUF_FULL;
               drop_s  = 1'b1;
            end else if (out_ready_i) begin
               state_d = BUF_EMPTY;
            end else begin
               state_d = BUF_FULL;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
         end
      endcase

      // A drop in the same cycle as a clear wins, so no event is lost.
      if (drop_s) begin
         overrun_d = 1'b1;
      end else if (clr_err_i) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Holding register state, data and overrun flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BUF_EMPTY;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = (state_q == BUF_FULL);
   assign overrun_o   = overrun_q;

endmodule

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Assembles an MSB-first serial bit stream into N-bit words. A frame marker
// (sync) restarts word assembly; completed words go to a single-entry
// valid/ready holding register that flags dropped words as overrun.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset (release synchronised externally)
//   bus    - serial_deserializer_if.slave: I, in_valid, sync, out_ready,
//            clr_err in; out_data, out_valid, overrun out
// All outputs come straight from flops; I and in_valid only reach them
// through the holding register.
// -----------------------------------------------------------------------------
module serial_deserializer
   import serdes_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_deserializer_if.slave  bus
);

   localparam int             CW   = cnt_width(N);
   localparam logic [CW-1:0]  LAST = CW'(N - 1);

   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  shreg_q, shreg_d;
   logic [N-1:0]  word_s;
   logic          complete_s;
   logic [N-1:0]  out_data_s;
   logic          out_valid_s;
   logic          overrun_s;

   // Bit counter and shift register next-state; sync beats completion.
   always_comb begin
      count_d    = count_q;
      shreg_d    = shreg_q;
      complete_s = 1'b0;
      word_s     = {shreg_q[N-2:0], bus.I};
      if (bus.in_valid) begin
         if (bus.sync) begin
            // Partial word thrown away; this bit is bit 0 of the new word.
            shreg_d = {{(N-1){1'b0}}, bus.I};
            count_d = CW'(1);
         end else if (count_q == LAST) begin
            shreg_d    = word_s;
            count_d    = '0;
            complete_s = 1'b1;
         end else begin
            shreg_d = word_s;
            count_d = count_q + CW'(1);
         end
      end else begin
         count_d = count_q;
         shreg_d = shreg_q;
      end
   end

   // Bit counter and assembly register flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         shreg_q <= '0;
      end else begin
         count_q <= count_d;
         shreg_q <= shreg_d;
      end
   end

   deser_out_buf #(
      .N (N)
   ) u_out_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .word_i      (word_s),
      .complete_i  (complete_s),
      .out_ready_i (bus.out_ready),
      .clr_err_i   (bus.clr_err),
      .out_data_o  (out_data_s),
      .out_valid_o (out_valid_s),
      .overrun_o   (overrun_s)
   );

   assign bus.out_data  = out_data_s;
   assign bus.out_valid = out_valid_s;
   assign bus.overrun   = overrun_s;

endmodule
